fifo_rd_ctrl: RTL and testbench

//  Read-side controller of the FIFO; drains the register file written by the write side.

---
 rtl/fifo_rd_ctrl.sv | 97 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read side of a single-clock FIFO. Owns the read pointer, drives the
//   asynchronous read address of the shared register file, and presents the
//   stored words on a registered valid/ready output stream. The read pointer
//   is exported so the write side can compute "full".
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous, active-high reset
//   w_ptr_i     write pointer from the write side (MSB is the wrap bit)
//   r_addr_o    read address to the register file (async read)
//   r_data_i    register file data for r_addr_o, valid in the same cycle
//   flush_i     discard stored words and the output word
//   m_valid_o   output word valid
//   m_ready_i   consumer accepts the output word
//   m_data_o    output word (registered)
//   rd_ptr_o    read pointer to the write side
//   count_o     words held in the register file (output register excluded)
//   empty_o     count_o == 0
//   err_o       sticky flag: pointers ever implied more than 2**AddrBits words

module fifo_rd_ctrl #(
    parameter int WordLength = 8,
    parameter int AddrBits   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AddrBits:0]     w_ptr_i,
    output logic [AddrBits-1:0]   r_addr_o,
    input  logic [WordLength-1:0] r_data_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WordLength-1:0] m_data_o,
    output logic [AddrBits:0]     rd_ptr_o,
    output logic [AddrBits:0]     count_o,
    output logic                  empty_o,
    output logic                  err_o
);

    localparam logic [AddrBits:0] Depth = {1'b1, {AddrBits{1'b0}}};

    logic [AddrBits:0]     rd_ptr;
    logic [AddrBits:0]     occ;
    logic                  load;

    logic [AddrBits:0]     rd_ptr_nxt;
    logic                  valid_nxt;
    logic [WordLength-1:0] data_nxt;
    logic                  err_nxt;

    // Modular subtraction on the extended pointers gives occupancy directly,
    // including across the wrap bit.
    assign occ      = w_ptr_i - rd_ptr;
    assign count_o  = occ;
    assign empty_o  = (occ == '0);
    assign r_addr_o = rd_ptr[AddrBits-1:0];
    assign rd_ptr_o = rd_ptr;

    // The output register can take a new word when it is empty or its
    // current word is leaving in this cycle.
    assign load = !empty_o && (!m_valid_o || m_ready_i);

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        valid_nxt  = m_valid_o;
        data_nxt   = m_data_o;
        // An occupancy above the depth can only come from inconsistent pointers.
        err_nxt    = err_o || (occ > Depth);

        if (flush_i) begin
            rd_ptr_nxt = w_ptr_i;
            valid_nxt  = 1'b0;
        end else if (load) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            valid_nxt  = 1'b1;
            data_nxt   = r_data_i;
        end else if (m_valid_o && m_ready_i) begin
            valid_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr    <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            err_o     <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            m_valid_o <= valid_nxt;
            m_data_o  <= data_nxt;
            err_o     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] w_ptr;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] rd_ptr;
    logic [3:0] count;
    logic       empty;
    logic       err;

    logic [7:0] mem [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign r_data = mem[r_addr];

    fifo_rd_ctrl #(.WordLength(8), .AddrBits(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .w_ptr_i   (w_ptr),
        .r_addr_o  (r_addr),
        .r_data_i  (r_data),
        .flush_i   (flush),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .rd_ptr_o  (rd_ptr),
        .count_o   (count),
        .empty_o   (empty),
        .err_o     (err)
    );

    typedef struct {
        logic       rst;
        logic       ready;
        logic       wr;
        logic [7:0] wdata;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] erd;
        logic [3:0] ecnt;
        logic       eempty;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic r, logic rdy, logic wr, logic [7:0] wd,
                                logic ev, logic [7:0] ed, logic [3:0] erd,
                                logic [3:0] ecnt, logic eempty);
        vec_t v;
        v.rst = r; v.ready = rdy; v.wr = wr; v.wdata = wd;
        v.ev = ev; v.ed = ed; v.erd = erd; v.ecnt = ecnt; v.eempty = eempty;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[w_ptr[2:0]] = d;
        w_ptr = w_ptr + 4'd1;
    endtask

    task automatic reset_seq();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; w_ptr = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model for the random phase: a queue of words held in the
    // register file plus the expected output register contents.
    logic [7:0] q [$];
    logic       mv;
    logic [7:0] md;
    logic [3:0] mrd;

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; w_ptr = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #1;

        // Reset, single-word stall, pop without load, stall with backlog.
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 4'd0, 1);
        tbl[1]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 4'd0, 1);
        tbl[2]  = mk(0, 0, 1, 8'hA5, 1, 8'hA5, 4'd1, 4'd0, 1);
        for (int i = 3; i < 8; i++)
            tbl[i] = mk(0, 0, 0, 8'h00, 1, 8'hA5, 4'd1, 4'd0, 1);
        tbl[8]  = mk(0, 1, 0, 8'h00, 0, 8'hA5, 4'd1, 4'd0, 1);
        tbl[9]  = mk(0, 0, 1, 8'h3C, 1, 8'h3C, 4'd2, 4'd0, 1);
        tbl[10] = mk(0, 0, 1, 8'h4D, 1, 8'h3C, 4'd2, 4'd1, 0);
        tbl[11] = mk(0, 1, 0, 8'h00, 1, 8'h4D, 4'd3, 4'd0, 1);

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            m_ready = tbl[i].ready;
            if (tbl[i].rst) w_ptr = 4'd0;
            if (tbl[i].wr) write_word(tbl[i].wdata);
            tick();
            chk($sformatf("tbl%0d valid", i), 32'(m_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d data", i), 32'(m_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d rd_ptr", i), 32'(rd_ptr), 32'(tbl[i].erd));
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d empty", i), 32'(empty), 32'(tbl[i].eempty));
            if (i == 1) chk("reset err", 32'(err), 32'd0);
        end
        rst = 1'b0;

        // Full register file drained at one word per cycle.
        reset_seq();
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        w_ptr = 4'd8;
        m_ready = 1'b1;
        #1;
        chk("fill count", 32'(count), 32'd8);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("burst%0d valid", k), 32'(m_valid), 32'd1);
            chk($sformatf("burst%0d data", k), 32'(m_data), 32'h10 + 32'(k));
            chk($sformatf("burst%0d rd_ptr", k), 32'(rd_ptr), 32'(k + 1));
            chk($sformatf("burst%0d count", k), 32'(count), 32'(7 - k));
        end
        tick();
        chk("burst end valid", 32'(m_valid), 32'd0);
        chk("burst end empty", 32'(empty), 32'd1);
        chk("burst end rd_ptr", 32'(rd_ptr), 32'd8);
        chk("burst end err", 32'(err), 32'd0);

        // Pointer wrap: move rd_ptr to 14 via two flushes, then w_ptr wraps to 0.
        reset_seq();
        w_ptr = 4'd7; flush = 1'b1;
        tick();
        w_ptr = 4'd14;
        tick();
        flush = 1'b0;
        chk("wrap setup rd_ptr", 32'(rd_ptr), 32'd14);
        mem[6] = 8'h66; mem[7] = 8'h77;
        w_ptr = 4'd0; m_ready = 1'b1;
        #1;
        chk("wrap count", 32'(count), 32'd2);
        chk("wrap r_addr", 32'(r_addr), 32'd6);
        tick();
        chk("wrap beat0 data", 32'(m_data), 32'h66);
        chk("wrap beat0 rd_ptr", 32'(rd_ptr), 32'd15);
        tick();
        chk("wrap beat1 data", 32'(m_data), 32'h77);
        chk("wrap beat1 rd_ptr", 32'(rd_ptr), 32'd0);
        tick();
        chk("wrap end valid", 32'(m_valid), 32'd0);
        chk("wrap end empty", 32'(empty), 32'd1);
        chk("wrap end err", 32'(err), 32'd0);

        // Flush with a valid output word and words still stored.
        reset_seq();
        w_ptr = 4'd1; flush = 1'b1;
        tick();
        flush = 1'b0;
        mem[1] = 8'h91;
        w_ptr = 4'd5;
        tick();
        chk("flush pre valid", 32'(m_valid), 32'd1);
        chk("flush pre rd_ptr", 32'(rd_ptr), 32'd2);
        chk("flush pre count", 32'(count), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush rd_ptr", 32'(rd_ptr), 32'd5);
        chk("flush valid", 32'(m_valid), 32'd0);
        chk("flush count", 32'(count), 32'd0);
        chk("flush data held", 32'(m_data), 32'h91);

        // Sticky error on an impossible occupancy.
        reset_seq();
        w_ptr = 4'd10;
        tick();
        chk("err set", 32'(err), 32'd1);
        w_ptr = 4'd0;
        tick();
        chk("err sticky 1", 32'(err), 32'd1);
        tick();
        chk("err sticky 2", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err cleared", 32'(err), 32'd0);

        // Random traffic against the queue model.
        reset_seq();
        q.delete();
        mv = 1'b0; md = 8'h00; mrd = 4'd0;
        for (int c = 0; c < 600; c++) begin
            logic [7:0] d;
            m_ready = ($urandom_range(3) != 0);
            flush   = ($urandom_range(40) == 0);
            if (q.size() < 8 && $urandom_range(1) == 1) begin
                d = 8'($urandom);
                write_word(d);
                q.push_back(d);
            end
            #1;
            chk("rnd count", 32'(count), 32'(q.size()));
            chk("rnd empty", 32'(empty), 32'(q.size() == 0));
            chk("rnd r_addr", 32'(r_addr), 32'(mrd[2:0]));
            if (flush) begin
                q.delete();
                mv = 1'b0;
                mrd = w_ptr;
            end else if (q.size() > 0 && (!mv || m_ready)) begin
                md = q.pop_front();
                mv = 1'b1;
                mrd = mrd + 4'd1;
            end else if (mv && m_ready) begin
                mv = 1'b0;
            end
            tick();
            chk("rnd valid", 32'(m_valid), 32'(mv));
            chk("rnd data", 32'(m_data), 32'(md));
            chk("rnd rd_ptr", 32'(rd_ptr), 32'(mrd));
        end
        flush = 1'b0;
        chk("rnd err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
